// File: rtl/vid_sync_delay_line.sv
// ============================================================================
// Module      : vid_sync_delay_line
// Description : Runtime-selectable sync/trigger delay line with frame-synchronous
//               delay changes, blanked refill and HV-trigger test-cursor overlay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vid_sync_delay_line #(
    parameter int MAX_DELAY     = 16,
    parameter int DELAY_BITS    = 7,
    parameter int DEFAULT_DELAY = 12,
    parameter int TRIG_WIDTH    = 48,
    parameter int CURSOR_TRIGS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            pc_ena,
    input  logic [DELAY_BITS-1:0] delay_sel,
    input  logic                  cursor_ena,
    input  logic [23:0]           cursor_rgb,
    input  logic                  hde_in,
    input  logic                  vde_in,
    input  logic                  hs_in,
    input  logic                  vs_in,
    input  logic [TRIG_WIDTH-1:0] HV_triggers_in,
    input  logic [7:0]            red_in,
    input  logic [7:0]            green_in,
    input  logic [7:0]            blue_in,
    output logic                  hde_out,
    output logic                  vde_out,
    output logic                  hs_out,
    output logic                  vs_out,
    output logic [TRIG_WIDTH-1:0] HV_triggers_out,
    output logic [7:0]            red,
    output logic [7:0]            green,
    output logic [7:0]            blue,
    output logic [DELAY_BITS-1:0] delay_active,
    output logic                  pipe_valid
);

    localparam int                    c_ENTRY_W = TRIG_WIDTH + 4;
    localparam logic [DELAY_BITS-1:0] c_ONE     = DELAY_BITS'(1);
    localparam logic [DELAY_BITS-1:0] c_MAX_D   = DELAY_BITS'(MAX_DELAY);
    localparam logic [DELAY_BITS-1:0] c_DEF_D   = DELAY_BITS'(DEFAULT_DELAY);

    localparam logic [0:0] c_ST_FILL = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [c_ENTRY_W-1:0]  r_pipe [MAX_DELAY];
    logic [DELAY_BITS-1:0] r_delay;
    logic [DELAY_BITS-1:0] r_fill_cnt;
    logic [0:0]            r_state;
    logic                  r_vs_prev;

    logic                  w_step;
    logic [c_ENTRY_W-1:0]  w_entry_in;
    logic [c_ENTRY_W-1:0]  w_tap;
    logic                  w_tap_hde;
    logic                  w_tap_vde;
    logic                  w_tap_hs;
    logic                  w_tap_vs;
    logic [TRIG_WIDTH-1:0] w_tap_trig;
    logic [DELAY_BITS-1:0] w_clamped;
    logic                  w_vs_rise;
    logic                  w_reload;
    logic                  w_run;
    logic                  w_cursor_hit;
    logic [23:0]           w_base_rgb;
    logic [23:0]           w_rgb;

    assign w_step     = (pc_ena == 4'd0);
    assign w_entry_in = {hde_in, vde_in, hs_in, vs_in, HV_triggers_in};
    assign w_run      = (r_state == c_ST_RUN);

    // r_pipe[0] holds the sample from the previous pixel step, so tap D-1 yields step n-D
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (w_step) begin
            r_pipe[0] <= w_entry_in;
            for (int i = 1; i < MAX_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_comb begin
        w_tap = r_pipe[0];
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (r_delay == DELAY_BITS'(i + 1)) begin
                w_tap = r_pipe[i];
            end
        end
    end

    assign w_tap_hde  = w_tap[c_ENTRY_W-1];
    assign w_tap_vde  = w_tap[c_ENTRY_W-2];
    assign w_tap_hs   = w_tap[c_ENTRY_W-3];
    assign w_tap_vs   = w_tap[c_ENTRY_W-4];
    assign w_tap_trig = w_tap[TRIG_WIDTH-1:0];

    always_comb begin
        w_clamped = delay_sel;
        if (delay_sel == '0) begin
            w_clamped = c_ONE;
        end else if (delay_sel > c_MAX_D) begin
            w_clamped = c_MAX_D;
        end
    end

    assign w_vs_rise = vs_in & ~r_vs_prev;
    assign w_reload  = w_vs_rise && (w_clamped != r_delay);

    // A reload wins over the fill countdown, so a new edge during FILL restarts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_delay    <= c_DEF_D;
            r_fill_cnt <= c_DEF_D;
            r_state    <= c_ST_FILL;
            r_vs_prev  <= 1'b0;
        end else if (w_step) begin
            r_vs_prev <= vs_in;
            if (w_reload) begin
                r_delay    <= w_clamped;
                r_fill_cnt <= w_clamped;
                r_state    <= c_ST_FILL;
            end else if (r_state == c_ST_FILL) begin
                if (r_fill_cnt != '0) begin
                    r_fill_cnt <= r_fill_cnt - c_ONE;
                end
                if (r_fill_cnt <= c_ONE) begin
                    r_state <= c_ST_RUN;
                end
            end
        end
    end

    assign w_cursor_hit = cursor_ena & (|w_tap_trig[CURSOR_TRIGS-1:0]);
    assign w_base_rgb   = {red_in, green_in, blue_in};
    assign w_rgb        = w_cursor_hit ? (w_base_rgb | cursor_rgb) : w_base_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hde_out         <= 1'b0;
            vde_out         <= 1'b0;
            hs_out          <= 1'b0;
            vs_out          <= 1'b0;
            HV_triggers_out <= '0;
            red             <= 8'd0;
            green           <= 8'd0;
            blue            <= 8'd0;
        end else if (w_step) begin
            hs_out          <= w_tap_hs;
            vs_out          <= w_tap_vs;
            hde_out         <= w_run & w_tap_hde;
            vde_out         <= w_run & w_tap_vde;
            HV_triggers_out <= w_run ? w_tap_trig : '0;
            {red, green, blue} <= w_run ? w_rgb : 24'd0;
        end
    end

    assign delay_active = r_delay;
    assign pipe_valid   = w_run;

endmodule

`default_nettype wire

// File: tb/tb_vid_sync_delay_line.sv
// ============================================================================
// Module      : tb_vid_sync_delay_line
// Description : Directed bench for vid_sync_delay_line with a history-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vid_sync_delay_line;

    localparam int MAXD = 16;
    localparam int DB   = 7;
    localparam int DEF  = 12;
    localparam int TW   = 48;
    localparam int CT   = 4;
    localparam int EW   = TW + 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    pc_ena;
    logic [DB-1:0] delay_sel;
    logic          cursor_ena;
    logic [23:0]   cursor_rgb;
    logic          hde_in, vde_in, hs_in, vs_in;
    logic [TW-1:0] HV_triggers_in;
    logic [7:0]    red_in, green_in, blue_in;
    logic          hde_out, vde_out, hs_out, vs_out;
    logic [TW-1:0] HV_triggers_out;
    logic [7:0]    red, green, blue;
    logic [DB-1:0] delay_active;
    logic          pipe_valid;

    int n_checks = 0;
    int n_fail   = 0;

    vid_sync_delay_line #(
        .MAX_DELAY(MAXD), .DELAY_BITS(DB), .DEFAULT_DELAY(DEF),
        .TRIG_WIDTH(TW), .CURSOR_TRIGS(CT)
    ) dut (
        .clk(clk), .reset(reset), .pc_ena(pc_ena), .delay_sel(delay_sel),
        .cursor_ena(cursor_ena), .cursor_rgb(cursor_rgb),
        .hde_in(hde_in), .vde_in(vde_in), .hs_in(hs_in), .vs_in(vs_in),
        .HV_triggers_in(HV_triggers_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hde_out(hde_out), .vde_out(vde_out), .hs_out(hs_out), .vs_out(vs_out),
        .HV_triggers_out(HV_triggers_out),
        .red(red), .green(green), .blue(blue),
        .delay_active(delay_active), .pipe_valid(pipe_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int clampd(input int s);
        if (s == 0) return 1;
        if (s > MAXD) return MAXD;
        return s;
    endfunction

    // Model: every pixel-step sample is appended to a history; the output at
    // step n is the sample from step n-D, blanked while refill steps remain.
    logic [EW-1:0] m_hist[$];
    logic [EW-1:0] m_tap;
    int            m_delay;
    int            m_blank;
    int            m_idx;
    bit            m_vs_prev;
    bit            m_isblank;
    logic [EW-1:0] exp_sync;
    logic [23:0]   exp_rgb;
    int            exp_da;
    bit            exp_pv;

    always @(posedge clk) begin
        if (reset) begin
            m_hist.delete();
            m_delay   = DEF;
            m_blank   = DEF;
            m_vs_prev = 1'b0;
            exp_sync  = '0;
            exp_rgb   = '0;
            exp_da    = DEF;
            exp_pv    = 1'b0;
        end else if (pc_ena == 4'd0) begin
            m_idx     = m_hist.size() - m_delay;
            m_tap     = (m_idx >= 0) ? m_hist[m_idx] : '0;
            m_isblank = (m_blank > 0);
            if (m_isblank) begin
                exp_sync = {2'b00, m_tap[EW-3], m_tap[EW-4], {TW{1'b0}}};
                exp_rgb  = 24'd0;
            end else begin
                exp_sync = m_tap;
                exp_rgb  = {red_in, green_in, blue_in};
                if (cursor_ena && (m_tap[CT-1:0] != '0)) exp_rgb = exp_rgb | cursor_rgb;
            end
            m_hist.push_back({hde_in, vde_in, hs_in, vs_in, HV_triggers_in});
            if (m_blank > 0) m_blank--;
            if (vs_in && !m_vs_prev && clampd(int'(delay_sel)) != m_delay) begin
                m_delay = clampd(int'(delay_sel));
                m_blank = m_delay;
            end
            m_vs_prev = vs_in;
            exp_pv    = (m_blank == 0);
            exp_da    = m_delay;
        end
        #1;
        chk("model_sync", {hde_out, vde_out, hs_out, vs_out, HV_triggers_out}, exp_sync);
        chk("model_rgb", {red, green, blue}, exp_rgb);
        chk("model_delay_active", delay_active, exp_da);
        chk("model_pipe_valid", pipe_valid, exp_pv);
    end

    initial begin
        pc_ena = 4'd0;
        forever begin
            @(negedge clk);
            pc_ena = (pc_ena == 4'd3) ? 4'd0 : pc_ena + 4'd1;
        end
    end

    // Advance k pixel steps, returning at the negedge after the last one
    task automatic px(input int k);
        for (int j = 0; j < k; j++) begin
            do @(posedge clk); while (pc_ena != 4'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        delay_sel = 7'd12;
        cursor_ena = 1'b0; cursor_rgb = 24'd0;
        hde_in = 1'b0; vde_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        HV_triggers_in = '0;
        red_in = 8'd0; green_in = 8'd0; blue_in = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_delay_active", delay_active, 12);
        chk("rst_pipe_valid", pipe_valid, 0);
        chk("rst_outputs", {hde_out, vde_out, hs_out, vs_out, HV_triggers_out, red, green, blue}, 0);
        reset = 1'b0;

        px(11); chk("fill12_pv_step11", pipe_valid, 0);
        px(1);  chk("fill12_pv_step12", pipe_valid, 1);

        hde_in = 1'b1; px(1); hde_in = 1'b0;
        px(11); chk("d12_pulse_early", hde_out, 0);
        px(1);  chk("d12_pulse", hde_out, 1);
        px(1);  chk("d12_pulse_late", hde_out, 0);

        cursor_ena = 1'b1; cursor_rgb = 24'h808000;
        for (int i = 0; i < 24; i++) begin
            {hde_in, vde_in, hs_in} = 3'($urandom);
            HV_triggers_in = TW'(1) << $urandom_range(0, 7);
            red_in = 8'($urandom); green_in = 8'($urandom); blue_in = 8'($urandom);
            px(1);
        end
        {hde_in, vde_in, hs_in} = 3'b000;
        HV_triggers_in = '0; cursor_ena = 1'b0;
        red_in = 8'd0; green_in = 8'd0; blue_in = 8'd0;

        delay_sel = 7'd3;
        px(5); chk("d3_not_before_edge", delay_active, 12);
        vs_in = 1'b1; px(1);
        chk("d3_active", delay_active, 3);
        chk("d3_pv_edge", pipe_valid, 0);
        px(2); chk("d3_vs_out_e2", vs_out, 0); chk("d3_pv_e2", pipe_valid, 0);
        px(1); chk("d3_vs_out_e3", vs_out, 1); chk("d3_pv_e3", pipe_valid, 1);
        vs_in = 1'b0; px(2);
        hde_in = 1'b1; vde_in = 1'b1; px(1); hde_in = 1'b0; vde_in = 1'b0;
        px(2); chk("d3_pulse_early", hde_out, 0);
        px(1); chk("d3_pulse", {hde_out, vde_out}, 2'b11);

        delay_sel = 7'd0; vs_in = 1'b1; px(1);
        chk("clamp0_active", delay_active, 1); chk("clamp0_pv", pipe_valid, 0);
        vs_in = 1'b0; px(1); chk("clamp0_pv_run", pipe_valid, 1);
        px(2);
        hde_in = 1'b1; px(1); chk("d1_same_step", hde_out, 0);
        hde_in = 1'b0; px(1); chk("d1_pulse", hde_out, 1);

        delay_sel = 7'd100; px(1); vs_in = 1'b1; px(1);
        chk("clamp100_active", delay_active, 16);
        vs_in = 1'b0;
        px(15); chk("d16_pv_e15", pipe_valid, 0);
        px(1);  chk("d16_pv_e16", pipe_valid, 1);
        px(2);
        delay_sel = 7'd16; vs_in = 1'b1; px(1);
        chk("equal_no_blank", pipe_valid, 1); chk("equal_active", delay_active, 16);
        vs_in = 1'b0; px(1);

        red_in = 8'h01; green_in = 8'h00; blue_in = 8'h22;
        cursor_ena = 1'b1; cursor_rgb = 24'h808000;
        HV_triggers_in = TW'(4); px(1); HV_triggers_in = '0;
        px(15); chk("cursor_before", {red, green, blue}, 24'h010022);
        px(1);  chk("cursor_hit", {red, green, blue}, 24'h818022);
        chk("cursor_trig2", HV_triggers_out[2], 1);
        px(1);  chk("cursor_after", {red, green, blue}, 24'h010022);
        HV_triggers_in = TW'(16); px(1); HV_triggers_in = '0;
        px(16); chk("cursor_trig4_out", HV_triggers_out[4], 1);
        chk("cursor_trig4_no_overlay", {red, green, blue}, 24'h010022);
        cursor_ena = 1'b0;
        HV_triggers_in = TW'(4); px(1); HV_triggers_in = '0;
        px(16); chk("cursor_off_trig", HV_triggers_out[2], 1);
        chk("cursor_off_no_overlay", {red, green, blue}, 24'h010022);

        delay_sel = 7'd10; vs_in = 1'b1; px(1);
        chk("restart_first", delay_active, 10);
        vs_in = 1'b0; delay_sel = 7'd8;
        px(5); chk("restart_pv_mid", pipe_valid, 0);
        vs_in = 1'b1; px(1); chk("restart_active", delay_active, 8);
        vs_in = 1'b0;
        px(7); chk("restart_pv_e13", pipe_valid, 0);
        px(1); chk("restart_pv_e14", pipe_valid, 1);

        delay_sel = 7'd5; px(1); vs_in = 1'b1; px(1); vs_in = 1'b0; px(1);
        @(posedge clk); #3;
        reset = 1'b1; #1;
        chk("async_rst_outputs", {hde_out, vde_out, hs_out, vs_out, HV_triggers_out, red, green, blue}, 0);
        chk("async_rst_active", delay_active, 12);
        chk("async_rst_pv", pipe_valid, 0);
        repeat (3) @(negedge clk);
        delay_sel = 7'd12; reset = 1'b0;
        px(11); chk("refill_pv_step11", pipe_valid, 0);
        px(1);  chk("refill_pv_step12", pipe_valid, 1);
        hs_in = 1'b1; HV_triggers_in = TW'(1); cursor_ena = 1'b1; px(1);
        hs_in = 1'b0; HV_triggers_in = '0;
        px(14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
